// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding,
// controller state encoding and the default multiply/divide wait limit.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG     = 2'd0,
        FWD_EX_ALU  = 2'd1,
        FWD_MEM_ALU = 2'd2,
        FWD_MEM_RD  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MUL_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_e;

    localparam int MUL_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One-operand forwarding priority: EX ALU result beats anything in MEM;
// in MEM, a load's read data is picked over its (meaningless) ALU result.
module hazard_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_wen,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_wen,
    input  logic       mem_load,
    output fwd_sel_e   sel
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = ex_wen && !ex_load && (ex_rd == rs);
    assign mem_match = mem_wen && (mem_rd == rs);

    // Priority select; register x0 and unused operands always read the regfile.
    always_comb begin
        sel = FWD_REG;
        if (rs == 5'd0 || !use_rs) begin
            sel = FWD_REG;
        end else if (ex_match) begin
            sel = FWD_EX_ALU;
        end else if (mem_match && mem_load) begin
            sel = FWD_MEM_RD;
        end else if (mem_match) begin
            sel = FWD_MEM_ALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// multi-cycle mul/div wait with timeout, and branch flush.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   ST_RUN        | normal issue; watches branch, mul start, load-use
//   ST_LOAD_STALL | one-cycle stall, bubble into EX while load reaches MEM
//   ST_MUL_WAIT   | front end held, EX holds mul/div until done or timeout
//   ST_FLUSH      | second cycle of a branch redirect flush
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_wen_i,
    input  logic        ex_mem_rd_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_wen_i,
    input  logic        mem_access_i,
    input  logic        branch_taken_i,
    input  logic        mul_start_i,
    input  logic        mul_done_i,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic        if_stall_o,
    output logic        id_stall_o,
    output logic        ex_bubble_o,
    output logic        id_flush_o,
    output logic        ex_flush_o,
    output logic        mul_timeout_o,
    output logic [15:0] stall_cnt_o
);

    localparam int CW = $clog2(MUL_TIMEOUT) + 1;

    state_e          state;
    state_e          state_nxt;
    logic [CW-1:0]   mul_cnt;
    logic            mul_load;
    logic            mul_dec;
    logic            timeout_set;
    logic            load_use;
    logic            if_stall;
    logic            id_stall;
    logic            ex_bubble;
    logic            flush;
    fwd_sel_e        fwd_a;
    fwd_sel_e        fwd_b;

    hazard_fwd_sel u_fwd_a (
        .rs       (id_rs1_i),
        .use_rs   (id_use_rs1_i),
        .ex_rd    (ex_rd_i),
        .ex_wen   (ex_wen_i),
        .ex_load  (ex_mem_rd_i),
        .mem_rd   (mem_rd_i),
        .mem_wen  (mem_wen_i),
        .mem_load (mem_access_i),
        .sel      (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs       (id_rs2_i),
        .use_rs   (id_use_rs2_i),
        .ex_rd    (ex_rd_i),
        .ex_wen   (ex_wen_i),
        .ex_load  (ex_mem_rd_i),
        .mem_rd   (mem_rd_i),
        .mem_wen  (mem_wen_i),
        .mem_load (mem_access_i),
        .sel      (fwd_b)
    );

    assign fwd_a_o = fwd_a;
    assign fwd_b_o = fwd_b;

    assign load_use = ex_mem_rd_i && ex_wen_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Next-state and stall/flush decode; branch > mul start > load-use.
    always_comb begin
        state_nxt   = state;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_bubble   = 1'b0;
        flush       = 1'b0;
        mul_load    = 1'b0;
        mul_dec     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken_i) begin
                    flush     = 1'b1;
                    state_nxt = ST_FLUSH;
                end else if (mul_start_i) begin
                    mul_load  = 1'b1;
                    state_nxt = ST_MUL_WAIT;
                end else if (load_use) begin
                    state_nxt = ST_LOAD_STALL;
                end
            end
            ST_LOAD_STALL: begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_bubble = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_MUL_WAIT: begin
                if (mul_done_i) begin
                    state_nxt = ST_RUN;
                end else begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    if (mul_cnt == '0) begin
                        timeout_set = 1'b1;
                        state_nxt   = ST_RUN;
                    end else begin
                        mul_dec = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Control outputs are forced quiet while reset is being sampled.
    assign if_stall_o  = if_stall  && !reset_i;
    assign id_stall_o  = id_stall  && !reset_i;
    assign ex_bubble_o = ex_bubble && !reset_i;
    assign id_flush_o  = flush     && !reset_i;
    assign ex_flush_o  = flush     && !reset_i;

    // State, wait down-counter, sticky timeout flag and saturating stall count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= ST_RUN;
            mul_cnt       <= '0;
            mul_timeout_o <= 1'b0;
            stall_cnt_o   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (mul_load) begin
                mul_cnt <= CW'(MUL_TIMEOUT - 1);
            end else if (mul_dec) begin
                mul_cnt <= mul_cnt - 1'b1;
            end
            if (timeout_set) begin
                mul_timeout_o <= 1'b1;
            end
            if (if_stall && stall_cnt_o != 16'hFFFF) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding priority, load-use stall,
// mul wait with done and timeout, branch flush and reset abandonment.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic        id_use_rs1_i, id_use_rs2_i;
    logic [4:0]  ex_rd_i;
    logic        ex_wen_i, ex_mem_rd_i;
    logic [4:0]  mem_rd_i;
    logic        mem_wen_i, mem_access_i;
    logic        branch_taken_i, mul_start_i, mul_done_i;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        if_stall_o, id_stall_o, ex_bubble_o, id_flush_o, ex_flush_o;
    logic        mul_timeout_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.MUL_TIMEOUT(64)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_use_rs1_i   (id_use_rs1_i),
        .id_use_rs2_i   (id_use_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .ex_wen_i       (ex_wen_i),
        .ex_mem_rd_i    (ex_mem_rd_i),
        .mem_rd_i       (mem_rd_i),
        .mem_wen_i      (mem_wen_i),
        .mem_access_i   (mem_access_i),
        .branch_taken_i (branch_taken_i),
        .mul_start_i    (mul_start_i),
        .mul_done_i     (mul_done_i),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .if_stall_o     (if_stall_o),
        .id_stall_o     (id_stall_o),
        .ex_bubble_o    (ex_bubble_o),
        .id_flush_o     (id_flush_o),
        .ex_flush_o     (ex_flush_o),
        .mul_timeout_o  (mul_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset_i = 1'b0;
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        ex_rd_i = 5'd0; ex_wen_i = 1'b0; ex_mem_rd_i = 1'b0;
        mem_rd_i = 5'd0; mem_wen_i = 1'b0; mem_access_i = 1'b0;
        branch_taken_i = 1'b0; mul_start_i = 1'b0; mul_done_i = 1'b0;
    endtask

    // Advance to the next falling edge; inputs are changed there and outputs
    // checked 1 time unit later, far from the rising edge.
    task automatic next();
        @(negedge clk_i);
    endtask

    task automatic quiet(input string tag);
        chk1({tag, "_if_stall"}, if_stall_o, 1'b0);
        chk1({tag, "_ex_bubble"}, ex_bubble_o, 1'b0);
        chk1({tag, "_id_flush"}, id_flush_o, 1'b0);
    endtask

    initial begin
        idle();
        // Reset cycle with branch and EX forwarding applied: flush gated, fwd valid.
        next();
        reset_i = 1'b1; branch_taken_i = 1'b1;
        ex_rd_i = 5'd5; ex_wen_i = 1'b1; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
        #1;
        chk1("rst_id_flush", id_flush_o, 1'b0);
        chk1("rst_ex_flush", ex_flush_o, 1'b0);
        chk1("rst_if_stall", if_stall_o, 1'b0);
        chk2("rst_fwd_a", fwd_a_o, 2'd1);
        next();
        idle();
        #1;
        chk16("rst_stall_cnt", stall_cnt_o, 16'd0);
        chk1("rst_timeout", mul_timeout_o, 1'b0);
        quiet("rst_after");

        // Forwarding priority on operand A, then operand B.
        next();
        ex_rd_i = 5'd5; ex_wen_i = 1'b1; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
        #1; chk2("fwd_a_ex", fwd_a_o, 2'd1); quiet("fwd_a_ex");
        next();
        mem_rd_i = 5'd5; mem_wen_i = 1'b1;
        #1; chk2("fwd_a_ex_over_mem", fwd_a_o, 2'd1);
        next();
        ex_wen_i = 1'b0;
        #1; chk2("fwd_a_mem_alu", fwd_a_o, 2'd2);
        next();
        mem_access_i = 1'b1;
        #1; chk2("fwd_a_mem_rd", fwd_a_o, 2'd3);
        next();
        id_use_rs1_i = 1'b0;
        #1; chk2("fwd_a_unused", fwd_a_o, 2'd0);
        next();
        idle();
        ex_rd_i = 5'd0; ex_wen_i = 1'b1; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1;
        #1; chk2("fwd_a_x0", fwd_a_o, 2'd0);
        next();
        idle();
        ex_rd_i = 5'd9; ex_wen_i = 1'b1; mem_rd_i = 5'd4; mem_wen_i = 1'b1;
        id_rs2_i = 5'd4; id_use_rs2_i = 1'b1; id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
        #1; chk2("fwd_b_mem_alu", fwd_b_o, 2'd2); chk2("fwd_a_ex_9", fwd_a_o, 2'd1);
        next();
        mem_wen_i = 1'b0;
        #1; chk2("fwd_b_no_wen", fwd_b_o, 2'd0);

        // Load-use on rs2: one stall cycle with bubble, then MEM read data forwarded.
        next();
        idle();
        ex_rd_i = 5'd7; ex_wen_i = 1'b1; ex_mem_rd_i = 1'b1;
        id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        #1; chk2("lu_fwd_b_ex_load", fwd_b_o, 2'd0); quiet("lu_detect");
        next();
        idle();
        id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        mem_rd_i = 5'd7; mem_wen_i = 1'b1; mem_access_i = 1'b1;
        #1;
        chk1("lu_if_stall", if_stall_o, 1'b1);
        chk1("lu_id_stall", id_stall_o, 1'b1);
        chk1("lu_ex_bubble", ex_bubble_o, 1'b1);
        chk2("lu_fwd_b_mem_rd", fwd_b_o, 2'd3);
        next();
        idle();
        #1; quiet("lu_done"); chk16("lu_stall_cnt", stall_cnt_o, 16'd1);

        // Load-use where the used index is a load with rd=x0: no stall.
        next();
        ex_mem_rd_i = 1'b1; ex_wen_i = 1'b1; ex_rd_i = 5'd0; id_use_rs1_i = 1'b1;
        next();
        idle();
        #1; quiet("lu_x0");

        // Multiply finishing after 10 wait cycles.
        next(); reset_i = 1'b1;
        next(); idle();
        mul_start_i = 1'b1;
        #1; quiet("mul_start");
        for (int i = 0; i < 10; i++) begin
            next();
            idle();
            if (i == 4) branch_taken_i = 1'b1;
            #1;
            chk1("mul_if_stall", if_stall_o, 1'b1);
            chk1("mul_id_stall", id_stall_o, 1'b1);
            chk1("mul_ex_bubble", ex_bubble_o, 1'b0);
            chk1("mul_branch_ignored", id_flush_o, 1'b0);
        end
        next();
        idle(); mul_done_i = 1'b1;
        #1; chk1("mul_done_stall_drop", if_stall_o, 1'b0);
        next();
        idle();
        #1;
        chk16("mul_stall_cnt", stall_cnt_o, 16'd10);
        quiet("mul_after");
        chk1("mul_no_timeout", mul_timeout_o, 1'b0);

        // Multiply never completing: 64 stall cycles, then sticky timeout.
        next();
        mul_start_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            next();
            idle();
            #1;
            chk1("to_if_stall", if_stall_o, 1'b1);
            chk1("to_flag_low", mul_timeout_o, 1'b0);
        end
        next();
        #1;
        chk1("to_exit_stall", if_stall_o, 1'b0);
        chk1("to_flag", mul_timeout_o, 1'b1);
        chk16("to_stall_cnt", stall_cnt_o, 16'd74);
        next(); next();
        #1; chk1("to_flag_sticky", mul_timeout_o, 1'b1);

        // Branch with concurrent load-use: two flush cycles, no stall.
        next();
        branch_taken_i = 1'b1;
        ex_rd_i = 5'd7; ex_wen_i = 1'b1; ex_mem_rd_i = 1'b1;
        id_rs1_i = 5'd7; id_use_rs1_i = 1'b1;
        #1;
        chk1("br_id_flush0", id_flush_o, 1'b1);
        chk1("br_ex_flush0", ex_flush_o, 1'b1);
        chk1("br_if_stall0", if_stall_o, 1'b0);
        next();
        branch_taken_i = 1'b0;
        #1;
        chk1("br_id_flush1", id_flush_o, 1'b1);
        chk1("br_ex_flush1", ex_flush_o, 1'b1);
        chk1("br_if_stall1", if_stall_o, 1'b0);
        chk1("br_id_stall1", id_stall_o, 1'b0);
        next();
        idle();
        #1;
        quiet("br_after");
        chk16("br_stall_cnt", stall_cnt_o, 16'd74);
        chk1("br_flag_sticky", mul_timeout_o, 1'b1);

        // Reset in the middle of a multiply wait.
        next(); mul_start_i = 1'b1;
        next(); idle();
        #1; chk1("rmw_stall", if_stall_o, 1'b1);
        next(); reset_i = 1'b1;
        #1; chk1("rmw_rst_stall", if_stall_o, 1'b0);
        next(); idle();
        #1;
        quiet("rmw_after");
        chk16("rmw_stall_cnt", stall_cnt_o, 16'd0);
        chk1("rmw_flag", mul_timeout_o, 1'b0);
        next();
        #1; quiet("rmw_after2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; reset_i  in  1  synchronous active-high reset (one clock; sync, active-high is fixed).
REQ-002 SHALL have ports: id_rs1_i, id_rs2_i  in  5 each  ID-stage source indices; id_use_rs1_i, id_use_rs2_i  in  1 each  source actually read.
REQ-003 SHALL have ports: ex_rd_i  in  5  EX dest; ex_wen_i  in  1  EX writes rd; ex_mem_rd_i  in  1  EX instr is load.
REQ-004 SHALL have ports: mem_rd_i  in  5  MEM dest; mem_wen_i  in  1; mem_access_i  in  1  MEM instr is load.
REQ-005 SHALL have ports: branch_taken_i  in  1  EX branch/jump redirect; mul_start_i  in  1  EX issues multi-cycle mul/div; mul_done_i  in  1  result ready.
REQ-006 SHALL have ports: fwd_a_o, fwd_b_o  out  2 each  operand source select; if_stall_o, id_stall_o, ex_bubble_o, id_flush_o, ex_flush_o  out  1 each; mul_timeout_o  out  1  sticky; stall_cnt_o  out  16  stall-cycle count.
REQ-007 SHALL use parameter MUL_TIMEOUT, default 64, meaning max MUL_WAIT cycles before abort.

Function
REQ-008 Forward select SHALL be combinational: 0=regfile, 1=EX ALU result, 2=MEM ALU result, 3=MEM read data.
REQ-009 Per operand: index 0 or use bit low -> 0; else EX match (ex_wen_i, not load) -> 1; else MEM match with mem_access_i -> 3; else MEM match -> 2; else 0. EX match SHALL beat MEM match.
REQ-010 Load-use hazard: ex_mem_rd_i && ex_wen_i && ex_rd_i!=0 && ex_rd_i equals a used ID source.
REQ-011 FSM states SHALL be RUN, LOAD_STALL, MUL_WAIT, FLUSH.
REQ-012 RUN: branch_taken_i -> FLUSH; else mul_start_i -> MUL_WAIT; else load-use -> LOAD_STALL; else RUN. Priority branch > mul > load-use.
REQ-013 LOAD_STALL SHALL last exactly 1 cycle: if_stall_o=id_stall_o=ex_bubble_o=1, then RUN (load now in MEM, select 3).
REQ-014 MUL_WAIT: if_stall_o=id_stall_o=1, ex_bubble_o=0 (EX holds); exit to RUN on mul_done_i (stall drops same cycle done is seen); branch_taken_i ignored.
REQ-015 MUL_WAIT SHALL count cycles; when count reaches MUL_TIMEOUT without done, set mul_timeout_o (sticky until reset) and return to RUN.
REQ-016 FLUSH SHALL last 1 cycle; id_flush_o and ex_flush_o asserted in the cycle branch_taken_i is sampled in RUN (combinational) and during FLUSH; no stalls in FLUSH; then RUN.
REQ-017 Load-use detected together with branch_taken_i SHALL cause no stall.
REQ-018 stall_cnt_o SHALL increment each cycle if_stall_o=1, saturating at 16'hFFFF (no wrap).
REQ-019 Forward selects SHALL remain valid in all states.

Reset
REQ-020 On reset_i sampled high: state=RUN, mul counter=0, mul_timeout_o=0, stall_cnt_o=0; all stall/flush outputs 0 in that cycle.
REQ-021 Reset mid-LOAD_STALL/MUL_WAIT/FLUSH SHALL abandon the operation with no residual stall after release.

Structure
REQ-022 Shared package SHALL hold fwd-select enum (REG, EX_ALU, MEM_ALU, MEM_RD), FSM state enum, and MUL_TIMEOUT default.
REQ-023 SHALL contain one sub-module, hazard_fwd_sel (one-operand comparator/priority logic), instantiated twice.
REQ-024 Target 150-300 lines RTL.

Verification
REQ-025 ex_rd=5,wen,non-load; id_rs1=5 used -> fwd_a=1, no stall; mem_rd=5 also -> still 1.
REQ-026 ex load rd=7; id_rs2=7 used -> 1 cycle if/id_stall+ex_bubble, next cycle mem_rd=7,mem_access -> fwd_b=3.
REQ-027 mul_start, mul_done after 10 cycles -> 10 stall cycles, stall_cnt_o=10, ex_bubble_o=0 throughout.
REQ-028 mul_start, no done, MUL_TIMEOUT=64 -> exit after 64 cycles, mul_timeout_o=1 until reset.
REQ-029 branch_taken with concurrent load-use -> id_flush/ex_flush 2 cycles, no stall; reset_i during MUL_WAIT -> RUN, counters 0.
